// File: rtl/matrix_host_sequencer.sv
// matrix_host_sequencer
// Host-side initiator for the matrix accelerator. It streams A/B element pairs
// into the accelerator, pulses start and waits for done (with a timeout). It
// then reads C back row-major and presents it on a valid/ready output stream.
module matrix_host_sequencer #(
  parameter int N            = 4,
  parameter int DATA_WIDTH   = 16,
  parameter int ACCUM_WIDTH  = 40,
  parameter int ADDR_WIDTH   = 8,
  parameter int READ_LATENCY = 2,
  parameter int TIMEOUT      = 22
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_start,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [DATA_WIDTH-1:0]  s_data_a,
  input  logic [DATA_WIDTH-1:0]  s_data_b,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [ACCUM_WIDTH-1:0] m_data,
  output logic                   m_last,
  output logic                   busy,
  output logic                   op_done,
  output logic                   error,
  output logic                   acc_load_a_b,
  output logic [ADDR_WIDTH-1:0]  acc_write_addr,
  output logic [DATA_WIDTH-1:0]  acc_write_data_a,
  output logic [DATA_WIDTH-1:0]  acc_write_data_b,
  output logic                   acc_start,
  input  logic                   acc_done,
  output logic [ADDR_WIDTH-1:0]  acc_read_addr,
  input  logic [ACCUM_WIDTH-1:0] acc_read_data_c
);

  localparam int NN    = N * N;
  localparam int IDX_W = $clog2(NN + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam int LAT_W = (READ_LATENCY < 2) ? 1 : $clog2(READ_LATENCY + 1);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NN - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(READ_LATENCY);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_START    = 3'd2,
    S_WAIT     = 3'd3,
    S_RD_ISSUE = 3'd4,
    S_RD_WAIT  = 3'd5,
    S_SEND     = 3'd6
  } state_e;

  state_e                 state_q;
  logic [IDX_W-1:0]       idx_q;
  logic [TMO_W-1:0]       tmo_q;
  logic [LAT_W-1:0]       lat_q;

  logic                   s_ready_q;
  logic                   m_valid_q;
  logic [ACCUM_WIDTH-1:0] m_data_q;
  logic                   m_last_q;
  logic                   busy_q;
  logic                   op_done_q;
  logic                   error_q;
  logic                   load_q;
  logic [ADDR_WIDTH-1:0]  waddr_q;
  logic [DATA_WIDTH-1:0]  wdata_a_q;
  logic [DATA_WIDTH-1:0]  wdata_b_q;
  logic                   start_q;
  logic [ADDR_WIDTH-1:0]  raddr_q;

  assign s_ready          = s_ready_q;
  assign m_valid          = m_valid_q;
  assign m_data           = m_data_q;
  assign m_last           = m_last_q;
  assign busy             = busy_q;
  assign op_done          = op_done_q;
  assign error            = error_q;
  assign acc_load_a_b     = load_q;
  assign acc_write_addr   = waddr_q;
  assign acc_write_data_a = wdata_a_q;
  assign acc_write_data_b = wdata_b_q;
  assign acc_start        = start_q;
  assign acc_read_addr    = raddr_q;

  // Sequencer FSM: load -> start -> wait -> read/send loop, all outputs registered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      tmo_q     <= '0;
      lat_q     <= '0;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
      busy_q    <= 1'b0;
      op_done_q <= 1'b0;
      error_q   <= 1'b0;
      load_q    <= 1'b0;
      waddr_q   <= '0;
      wdata_a_q <= '0;
      wdata_b_q <= '0;
      start_q   <= 1'b0;
      raddr_q   <= '0;
    end else begin
      // single-cycle strobes fall back to zero unless re-asserted below
      op_done_q <= 1'b0;
      load_q    <= 1'b0;
      start_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cmd_start) begin
            state_q   <= S_LOAD;
            idx_q     <= '0;
            error_q   <= 1'b0;
            busy_q    <= 1'b1;
            s_ready_q <= 1'b1;
          end
        end
        S_LOAD: begin
          if (s_valid && s_ready_q) begin
            load_q    <= 1'b1;
            waddr_q   <= ADDR_WIDTH'(idx_q);
            wdata_a_q <= s_data_a;
            wdata_b_q <= s_data_b;
            if (idx_q == LAST_IDX) begin
              s_ready_q <= 1'b0;
              idx_q     <= '0;
              state_q   <= S_START;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end
        S_START: begin
          // the final write strobe is visible here, so start follows one cycle later
          start_q <= 1'b1;
          tmo_q   <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (acc_done) begin
            idx_q   <= '0;
            state_q <= S_RD_ISSUE;
          end else if (tmo_q == TMO_LAST) begin
            error_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end
        S_RD_ISSUE: begin
          raddr_q <= ADDR_WIDTH'(idx_q);
          lat_q   <= LAT_W'(1);
          state_q <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          // lat_q counts edges since the address update; capture on the last one
          if (lat_q == LAT_LAST) begin
            m_data_q  <= acc_read_data_c;
            m_valid_q <= 1'b1;
            m_last_q  <= (idx_q == LAST_IDX);
            state_q   <= S_SEND;
          end else begin
            lat_q <= lat_q + LAT_W'(1);
          end
        end
        S_SEND: begin
          if (m_ready) begin
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            if (m_last_q) begin
              busy_q    <= 1'b0;
              op_done_q <= 1'b1;
              state_q   <= S_IDLE;
            end else begin
              idx_q   <= idx_q + IDX_W'(1);
              state_q <= S_RD_ISSUE;
            end
          end
        end
        default: begin
          state_q   <= S_IDLE;
          busy_q    <= 1'b0;
          s_ready_q <= 1'b0;
          m_valid_q <= 1'b0;
          m_last_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_host_sequencer.sv
// Testbench for matrix_host_sequencer: a behavioural accelerator model on the
// acc_* side, a randomly stalling sink on the output stream, and a golden
// matrix product computed directly from the stimulus matrices.
module tb_matrix_host_sequencer;

  localparam int N   = 4;
  localparam int NN  = N * N;
  localparam int DW  = 16;
  localparam int CW  = 40;
  localparam int ADW = 8;
  localparam int TMO = 22;

  logic           clk = 1'b0;
  logic           reset;
  logic           cmd_start;
  logic           s_valid;
  logic           s_ready;
  logic [DW-1:0]  s_data_a;
  logic [DW-1:0]  s_data_b;
  logic           m_valid;
  logic           m_ready = 1'b0;
  logic [CW-1:0]  m_data;
  logic           m_last;
  logic           busy;
  logic           op_done;
  logic           error;
  logic           acc_load_a_b;
  logic [ADW-1:0] acc_write_addr;
  logic [DW-1:0]  acc_write_data_a;
  logic [DW-1:0]  acc_write_data_b;
  logic           acc_start;
  logic           acc_done = 1'b0;
  logic [ADW-1:0] acc_read_addr;
  logic [CW-1:0]  acc_read_data_c = '0;

  matrix_host_sequencer #(
    .N(N), .DATA_WIDTH(DW), .ACCUM_WIDTH(CW), .ADDR_WIDTH(ADW),
    .READ_LATENCY(2), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset), .cmd_start(cmd_start),
    .s_valid(s_valid), .s_ready(s_ready), .s_data_a(s_data_a), .s_data_b(s_data_b),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .op_done(op_done), .error(error),
    .acc_load_a_b(acc_load_a_b), .acc_write_addr(acc_write_addr),
    .acc_write_data_a(acc_write_data_a), .acc_write_data_b(acc_write_data_b),
    .acc_start(acc_start), .acc_done(acc_done),
    .acc_read_addr(acc_read_addr), .acc_read_data_c(acc_read_data_c)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- accelerator model and stream sink ----------------
  longint        mem_a [NN];
  longint        mem_b [NN];
  longint        mem_c [NN];
  int            load_cnt, start_cnt, done_pulses, cyc, start_cyc, err_cyc;
  int            done_dly, dcnt, ready_mode, prev_raddr;
  bit            armed, err_prev, stall_prev, stall_last;
  logic [CW-1:0] stall_data;
  logic [CW-1:0] out_data[$];
  bit            out_last[$];

  function automatic void compute_c();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        longint acc = 0;
        for (int k = 0; k < N; k++) acc += mem_a[i*N+k] * mem_b[k*N+j];
        mem_c[i*N+j] = acc;
      end
  endfunction

  initial begin
    cyc = 0; prev_raddr = 0; armed = 1'b0; err_prev = 1'b0; stall_prev = 1'b0;
    done_dly = 0; dcnt = 0; ready_mode = 0;
    for (int i = 0; i < NN; i++) begin mem_a[i] = 0; mem_b[i] = 0; mem_c[i] = 0; end
  end

  // Everything observed/driven on the accelerator and sink sides, half a cycle from the active edge
  always @(negedge clk) begin
    bit r;
    cyc++;
    if (reset) begin
      stall_prev = 1'b0;
      m_ready    = 1'b0;
      err_prev   = 1'b0;
    end else begin
      if (acc_load_a_b) begin
        check("wr_addr_order", 64'(acc_write_addr), 64'(load_cnt));
        if (int'(acc_write_addr) < NN) begin
          mem_a[acc_write_addr] = longint'($signed(acc_write_data_a));
          mem_b[acc_write_addr] = longint'($signed(acc_write_data_b));
        end
        load_cnt++;
      end
      if (acc_start) begin
        start_cnt++;
        start_cyc = cyc;
        armed = (done_dly > 0);
        dcnt  = done_dly - 1;
        if (done_dly == 0) begin compute_c(); acc_done = 1'b1; end
        else acc_done = 1'b0;
      end else if (armed) begin
        if (dcnt == 0) begin compute_c(); acc_done = 1'b1; armed = 1'b0; end
        else dcnt--;
      end
      // one-register read pipeline: data follows the address by one more edge
      acc_read_data_c = CW'(mem_c[prev_raddr]);
      prev_raddr = (int'(acc_read_addr) < NN) ? int'(acc_read_addr) : 0;
      if (op_done) done_pulses++;
      if (error && !err_prev) err_cyc = cyc;
      err_prev = error;
      if (stall_prev)
        check("m_hold_stable", {22'd0, m_valid, m_last, m_data}, {22'd0, 1'b1, stall_last, stall_data});
      case (ready_mode)
        0:       r = 1'b1;
        1:       r = ($urandom_range(0, 2) == 0);
        default: r = ($urandom_range(0, 1) == 1);
      endcase
      m_ready = r;
      if (m_valid && r) begin out_data.push_back(m_data); out_last.push_back(m_last); end
      stall_prev = m_valid && !r;
      stall_data = m_data;
      stall_last = m_last;
    end
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  typedef struct {
    int pat;       // 0 identity/ramp, 1 random [-100,100], 2 full-scale extremes
    bit gaps;      // random s_valid gaps
    int rmode;     // sink ready mode
    int dly;       // cycles from acc_start to acc_done, -1 = never
    bit inj;       // pulse cmd_start while waiting for done
    int abort_at;  // reset while this beat is on the output, -1 = no abort
    bit exp_err;
    int exp_beats;
  } vec_t;

  task automatic run_op(input vec_t v, input int id);
    int     a [NN];
    int     b [NN];
    longint gold [NN];
    int     k, guard, nb;
    string  tag;
    tag = $sformatf("op%0d", id);
    for (int i = 0; i < NN; i++) begin
      case (v.pat)
        0:       begin a[i] = ((i / N) == (i % N)) ? 1 : 0; b[i] = i - 8; end
        1:       begin a[i] = int'($urandom_range(0, 200)) - 100; b[i] = int'($urandom_range(0, 200)) - 100; end
        default: begin a[i] = ($urandom_range(0, 1) == 1) ? 32767 : -32768; b[i] = -32768; end
      endcase
    end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        gold[i*N+j] = 0;
        for (int m = 0; m < N; m++) gold[i*N+j] += longint'(a[i*N+m]) * longint'(b[m*N+j]);
      end
    load_cnt = 0; start_cnt = 0; done_pulses = 0; err_cyc = -1; start_cyc = -1;
    out_data.delete(); out_last.delete();
    done_dly = v.dly; ready_mode = v.rmode; armed = 1'b0;

    step(); cmd_start = 1'b1;
    step(); cmd_start = 1'b0;
    check({tag, "_err_clear"}, 64'(error), 64'(0));
    check({tag, "_busy_load"}, {62'd0, busy, s_ready}, {62'd0, 1'b1, 1'b1});

    k = 0; guard = 0;
    while (k < NN && guard < 500) begin
      if (v.gaps && $urandom_range(0, 2) == 0) s_valid = 1'b0;
      else begin s_valid = 1'b1; s_data_a = DW'(a[k]); s_data_b = DW'(b[k]); end
      if (s_valid && s_ready) k++;
      step(); guard++;
    end
    s_valid = 1'b0;
    check({tag, "_beats_loaded"}, 64'(k), 64'(NN));

    if (v.inj) begin
      guard = 0;
      while (start_cnt == 0 && guard < 20) begin step(); guard++; end
      step(); step(); cmd_start = 1'b1;
      step(); cmd_start = 1'b0;
    end

    guard = 0;
    while (done_pulses == 0 && err_cyc < 0 && guard < 2000) begin
      if (v.abort_at >= 0 && out_data.size() == v.abort_at + 1 && m_valid) begin
        reset = 1'b1;
        #1;
        check({tag, "_abort_outs_zero"},
              64'(|{s_ready, m_valid, m_data, m_last, busy, op_done, error, acc_load_a_b,
                    acc_write_addr, acc_write_data_a, acc_write_data_b, acc_start, acc_read_addr}),
              64'(0));
        step(); reset = 1'b0;
        step();
        return;
      end
      step(); guard++;
    end
    check({tag, "_finished"}, 64'(guard < 2000), 64'(1));
    check({tag, "_busy_end"}, 64'(busy), 64'(0));
    check({tag, "_n_loads"}, 64'(load_cnt), 64'(NN));
    check({tag, "_n_starts"}, 64'(start_cnt), 64'(1));
    check({tag, "_n_beats"}, 64'(out_data.size()), 64'(v.exp_beats));
    nb = (out_data.size() < v.exp_beats) ? out_data.size() : v.exp_beats;
    for (int i = 0; i < nb; i++) begin
      logic [CW-1:0] g;
      g = CW'(gold[i]);
      check($sformatf("%s_c%0d", tag, i), {24'd0, out_data[i]}, {24'd0, g});
      check($sformatf("%s_last%0d", tag, i), 64'(out_last[i]), 64'(i == NN - 1));
    end
    check({tag, "_op_done_cnt"}, 64'(done_pulses), 64'(v.exp_err ? 0 : 1));
    if (v.exp_err) check({tag, "_tmo_cycles"}, 64'(err_cyc - start_cyc), 64'(TMO));
    step();
    check({tag, "_error_flag"}, 64'(error), 64'(v.exp_err));
    check({tag, "_op_done_low"}, 64'(op_done), 64'(0));
  endtask

  vec_t vecs [6];
  vec_t abort_v;

  initial begin
    reset = 1'b1; cmd_start = 1'b0; s_valid = 1'b0; s_data_a = '0; s_data_b = '0;
    repeat (3) @(negedge clk);
    #2;
    check("reset_outs_zero",
          64'(|{s_ready, m_valid, m_data, m_last, busy, op_done, error, acc_load_a_b,
                acc_write_addr, acc_write_data_a, acc_write_data_b, acc_start, acc_read_addr}),
          64'(0));
    reset = 1'b0;
    step(); step();
    check("idle_after_reset", {61'd0, busy, s_ready, error}, 64'(0));

    //          pat gaps rmode dly inj abort err beats
    vecs[0] = '{0, 1'b0, 0,  0, 1'b0, -1, 1'b0, NN};
    vecs[1] = '{1, 1'b0, 1,  3, 1'b0, -1, 1'b0, NN};
    vecs[2] = '{1, 1'b1, 2, 10, 1'b1, -1, 1'b0, NN};
    vecs[3] = '{2, 1'b1, 1,  5, 1'b0, -1, 1'b0, NN};
    vecs[4] = '{1, 1'b0, 0, -1, 1'b0, -1, 1'b1, 0};
    vecs[5] = '{1, 1'b1, 1,  2, 1'b0, -1, 1'b0, NN};
    for (int i = 0; i < 6; i++) run_op(vecs[i], i);

    // reset while beat 7 is on the output, then a fresh operation must be exact
    abort_v = '{1, 1'b0, 0, 2, 1'b0, 7, 1'b0, NN};
    run_op(abort_v, 6);
    check("abort_idle", {62'd0, busy, m_valid}, 64'(0));
    run_op(vecs[1], 7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
